// File: rtl/bypass_scoreboard_pkg.sv
// Shared constants for the bypass/scoreboard block: stage indices,
// forward-select encoding and the long-latency counter width.
package bypass_scoreboard_pkg;

    localparam int STG_EXE  = 0;
    localparam int STG_MEM  = 1;
    localparam int STG_WB   = 2;

    // fwd_sel value meaning "take the operand from the register file"
    localparam int FWD_RF   = 0;

    // Wide enough for LO_LAT up to 255
    localparam int LO_CNT_W = 8;

endpackage

// File: rtl/bypass_port_sel.sv
// One ID-stage read port: finds the youngest stage writing the requested
// register and reports whether that forward or the scoreboard forces a stall.
module bypass_port_sel
    import bypass_scoreboard_pkg::*;
#(
    parameter int NUM_STG      = 3,
    parameter int AW           = 5,
    parameter int LOAD_RDY_STG = 3,
    parameter int SELW         = 2
) (
    input  logic                  reader_valid_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [NUM_STG-1:0]    stg_valid_i,
    input  logic [NUM_STG-1:0]    stg_wen_i,
    input  logic [NUM_STG*AW-1:0] stg_waddr_i,
    input  logic [NUM_STG-1:0]    stg_load_i,
    input  logic                  pend_v_i,
    input  logic [AW-1:0]         pend_addr_i,
    output logic [SELW-1:0]       sel_o,
    output logic                  load_stall_o,
    output logic                  pend_stall_o
);

    logic active;

    // r0 is hardwired zero, so it never participates in forwarding or stalls
    assign active = reader_valid_i & rd_en_i & (rd_addr_i != '0);

    // Walk oldest to youngest so the youngest (lowest index) hit wins
    always_comb begin
        sel_o        = SELW'(FWD_RF);
        load_stall_o = 1'b0;
        for (int s = NUM_STG - 1; s >= 0; s--) begin
            if (active && stg_valid_i[s] && stg_wen_i[s] &&
                (stg_waddr_i[s*AW +: AW] == rd_addr_i)) begin
                sel_o        = SELW'(s + 1);
                load_stall_o = stg_load_i[s] && (s < LOAD_RDY_STG);
            end
        end
    end

    assign pend_stall_o = active & pend_v_i & (pend_addr_i == rd_addr_i);

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass selection plus a single-entry scoreboard for one
// outstanding long-latency op, with the combined ID-stage stall.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int NUM_RD       = 2,
    parameter int NUM_STG      = 3,
    parameter int AW           = 5,
    parameter int LOAD_RDY_STG = 3,
    parameter int LO_LAT       = 8,
    parameter int SELW         = $clog2(NUM_STG + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   de_valid,
    input  logic                   is_j_or_b,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    input  logic [NUM_STG-1:0]     stg_valid,
    input  logic [NUM_STG-1:0]     stg_wen,
    input  logic [NUM_STG*AW-1:0]  stg_waddr,
    input  logic [NUM_STG-1:0]     stg_load,
    input  logic                   lo_issue,
    input  logic [AW-1:0]          lo_waddr,
    input  logic                   flush,
    output logic [NUM_RD*SELW-1:0] fwd_sel,
    output logic                   stall,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   lo_busy,
    output logic                   lo_wb,
    output logic [AW-1:0]          lo_wb_addr,
    output logic [31:0]            stall_cnt
);

    logic [LO_CNT_W-1:0] cnt_q, cnt_d;
    logic                pend_v_q, pend_v_d;
    logic [AW-1:0]       pend_addr_q, pend_addr_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    logic                reader_valid;
    logic [NUM_RD-1:0]   load_stall;
    logic [NUM_RD-1:0]   pend_stall;
    logic                struct_stall;
    logic                accept;

    assign reader_valid = de_valid | is_j_or_b;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        bypass_port_sel #(
            .NUM_STG      (NUM_STG),
            .AW           (AW),
            .LOAD_RDY_STG (LOAD_RDY_STG),
            .SELW         (SELW)
        ) u_port_sel (
            .reader_valid_i (reader_valid),
            .rd_en_i        (rd_en[k]),
            .rd_addr_i      (rd_addr[k*AW +: AW]),
            .stg_valid_i    (stg_valid),
            .stg_wen_i      (stg_wen),
            .stg_waddr_i    (stg_waddr),
            .stg_load_i     (stg_load),
            .pend_v_i       (pend_v_q),
            .pend_addr_i    (pend_addr_q),
            .sel_o          (fwd_sel[k*SELW +: SELW]),
            .load_stall_o   (load_stall[k]),
            .pend_stall_o   (pend_stall[k])
        );
    end

    // A new long op may issue in the completion cycle (count == 1), not before
    assign struct_stall = lo_issue & de_valid & (cnt_q > LO_CNT_W'(1));

    assign stall    = rst & ~flush & ((|load_stall) | (|pend_stall) | struct_stall);
    assign pc_write = ~stall;
    assign ir_write = ~stall;

    assign accept     = rst & lo_issue & de_valid & ~stall & ~flush;
    assign lo_busy    = rst & (cnt_q != '0);
    assign lo_wb      = rst & ~flush & (cnt_q == LO_CNT_W'(1));
    assign lo_wb_addr = pend_addr_q;

    always_comb begin
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            cnt_d    = '0;
            pend_v_d = 1'b0;
        end else if (accept) begin
            cnt_d       = LO_CNT_W'(LO_LAT);
            pend_v_d    = (lo_waddr != '0);
            pend_addr_d = lo_waddr;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == LO_CNT_W'(1)) begin
                pend_v_d = 1'b0;
            end
        end
        if (stall && de_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
